word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 122 ++++++++++++
 tb/tb_word_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: buffers masked bus entries in a small FIFO and emits them one word per cycle, MSW first
module word_serializer #(
    parameter int BUS_SIZE   = 16,
    parameter int WORD_SIZE  = 4,
    parameter int WORD_NUM   = BUS_SIZE / WORD_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  data_in,
    input  logic [WORD_NUM-1:0]  ctrl_in,
    input  logic                 err_in,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 valid_out,
    output logic                 sop_out,
    output logic                 eop_out,
    output logic [2:0]           fifo_count,
    output logic                 overflow,
    output logic                 err_out,
    output logic [1:0]           estado
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = WORD_NUM > 1 ? $clog2(WORD_NUM) : 1;
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [SW-1:0] POS_FIRST = SW'(WORD_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        ERROR = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_SIZE-1:0]  fifo_data [FIFO_DEPTH];
    logic [WORD_NUM-1:0]  fifo_mask [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]           count_q, count_d;
    logic [BUS_SIZE-1:0]  sh_data_q, sh_data_d;
    logic [WORD_NUM-1:0]  sh_mask_q, sh_mask_d;
    logic [SW-1:0]        pos_q, pos_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 ovf_q, ovf_d;
    logic                 err_out_q;
    logic                 fifo_empty, fifo_full, last_pos, push_req, push, pop, shifting;

    // FIFO bookkeeping, shifter sequencing and the next value of every registered output
    always_comb begin
        fifo_empty = count_q == 3'd0;
        fifo_full  = count_q == 3'(FIFO_DEPTH);
        last_pos   = state_q == SHIFT && pos_q == '0;
        push_req   = !err_in && ctrl_in != '0;
        pop        = !err_in && !fifo_empty && (state_q != SHIFT || last_pos);
        push       = push_req && (!fifo_full || pop);
        wr_ptr_d   = err_in ? '0 : push ? (wr_ptr_q == PTR_LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = err_in ? '0 : pop ? (rd_ptr_q == PTR_LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d    = err_in ? 3'd0 : count_q + {2'b00, push} - {2'b00, pop};
        ovf_d      = ovf_q | (push_req && !push);
        state_d    = err_in ? ERROR : pop ? SHIFT : (state_q == SHIFT && !last_pos) ? SHIFT : IDLE;
        sh_data_d  = err_in ? '0 : pop ? fifo_data[rd_ptr_q] : sh_data_q;
        sh_mask_d  = err_in ? '0 : pop ? fifo_mask[rd_ptr_q] : sh_mask_q;
        pos_d      = pop ? POS_FIRST : (state_q == SHIFT && !last_pos) ? pos_q - 1'b1 : '0;
        shifting   = state_d == SHIFT;
        word_d     = shifting ? sh_data_d[pos_d*WORD_SIZE +: WORD_SIZE] : '0;
        valid_d    = shifting && sh_mask_d[pos_d];
        sop_d      = shifting && pos_d == POS_FIRST;
        eop_d      = shifting && pos_d == '0;
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= data_in;
            fifo_mask[wr_ptr_q] <= ctrl_in;
        end
    end

    // State, pointers, shifter and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sh_data_q <= '0;
            sh_mask_q <= '0;
            pos_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sh_data_q <= sh_data_d;
            sh_mask_q <= sh_mask_d;
            pos_q     <= pos_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            ovf_q     <= ovf_d;
            err_out_q <= err_in;
        end
    end

    assign word_out   = word_q;
    assign valid_out  = valid_q;
    assign sop_out    = sop_q;
    assign eop_out    = eop_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign err_out    = err_out_q;
    assign estado     = state_q;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed and randomized checks of word_serializer against a queue-based model
module tb_word_serializer;
    localparam int BS = 16;
    localparam int WS = 4;
    localparam int WN = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BS-1:0] data_in = '0;
    logic [WN-1:0] ctrl_in = '0;
    logic          err_in = 1'b0;
    logic [WS-1:0] word_out;
    logic          valid_out, sop_out, eop_out, overflow, err_out;
    logic [2:0]    fifo_count;
    logic [1:0]    estado;
    logic [13:0]   outs;

    int checks = 0;
    int errors = 0;

    logic [BS-1:0] mq_data [$];
    logic [WN-1:0] mq_mask [$];
    logic [BS-1:0] m_data;
    logic [WN-1:0] m_mask;
    int            m_left;
    bit            m_ovf, m_err, m_in_err;

    word_serializer #(.BUS_SIZE(BS), .WORD_SIZE(WS), .WORD_NUM(WN), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .ctrl_in(ctrl_in), .err_in(err_in),
        .word_out(word_out), .valid_out(valid_out), .sop_out(sop_out), .eop_out(eop_out),
        .fifo_count(fifo_count), .overflow(overflow), .err_out(err_out), .estado(estado)
    );

    assign outs = {word_out, valid_out, sop_out, eop_out, fifo_count, overflow, err_out, estado};

    always #5 clk = ~clk;

    task automatic model_reset();
        mq_data.delete();
        mq_mask.delete();
        m_left = 0;
        m_ovf = 0;
        m_err = 0;
        m_in_err = 0;
    endtask

    // m_left counts the words of the current entry still to be shown, including the one on the output
    task automatic model_edge(input logic [BS-1:0] d, input logic [WN-1:0] c, input logic e);
        bit pop;
        m_err = e;
        if (e) begin
            mq_data.delete();
            mq_mask.delete();
            m_left = 0;
            m_in_err = 1;
        end else begin
            m_in_err = 0;
            pop = mq_data.size() > 0 && m_left <= 1;
            if (pop) begin
                m_data = mq_data.pop_front();
                m_mask = mq_mask.pop_front();
                m_left = WN;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (c != '0) begin
                if (mq_data.size() < FD) begin
                    mq_data.push_back(d);
                    mq_mask.push_back(c);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic tick(input logic [BS-1:0] d, input logic [WN-1:0] c, input logic e);
        data_in = d;
        ctrl_in = c;
        err_in = e;
        @(posedge clk);
        model_edge(d, c, e);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (outs !== 14'h0) begin errors++; $display("FAIL reset_async outs=%h exp=%h", outs, 14'h0); end
        #1 reset = 1'b1;
        tick('0, '0, 1'b0);
        tick('0, '0, 1'b0);
        checks++;
        if (outs !== 14'h0) begin errors++; $display("FAIL reset_idle outs=%h exp=%h", outs, 14'h0); end
    endtask

    task automatic test_single();
        logic [WS-1:0] w [4] = '{4'hF, 4'h1, 4'hA, 4'h5};
        do_reset();
        tick(16'hF1A5, 4'b1111, 1'b0);
        checks++;
        if (word_out !== 4'h0 || valid_out !== 1'b0 || fifo_count !== 3'd1)
            begin errors++; $display("FAIL single_latency word=%h valid=%b count=%0d exp 0/0/1", word_out, valid_out, fifo_count); end
        for (int i = 0; i < 4; i++) begin
            tick('0, '0, 1'b0);
            checks++;
            if (word_out !== w[i] || valid_out !== 1'b1 || sop_out !== (i == 0) || eop_out !== (i == 3) || estado !== 2'b01)
                begin errors++; $display("FAIL single_word%0d word=%h v=%b sop=%b eop=%b st=%0d exp word=%h v=1 sop=%b eop=%b st=1", i, word_out, valid_out, sop_out, eop_out, estado, w[i], i == 0, i == 3); end
        end
        tick('0, '0, 1'b0);
        checks++;
        if (estado !== 2'b00 || valid_out !== 1'b0 || word_out !== 4'h0 || sop_out !== 1'b0 || eop_out !== 1'b0)
            begin errors++; $display("FAIL single_end st=%0d v=%b word=%h exp st=0 v=0 word=0", estado, valid_out, word_out); end
    endtask

    task automatic test_mask();
        logic [WS-1:0] w [4] = '{4'hF, 4'h2, 4'hC, 4'h3};
        logic          v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        tick(16'hF2C3, 4'b1010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick('0, '0, 1'b0);
            checks++;
            if (word_out !== w[i] || valid_out !== v[i] || sop_out !== (i == 0) || eop_out !== (i == 3))
                begin errors++; $display("FAIL mask_word%0d word=%h v=%b sop=%b eop=%b exp word=%h v=%b", i, word_out, valid_out, sop_out, eop_out, w[i], v[i]); end
        end
        tick(16'h1234, 4'b0000, 1'b0);
        tick('0, '0, 1'b0);
        checks++;
        if (fifo_count !== 3'd0 || valid_out !== 1'b0 || estado !== 2'b00 || sop_out !== 1'b0)
            begin errors++; $display("FAIL mask_zero count=%0d v=%b st=%0d exp 0/0/0", fifo_count, valid_out, estado); end
    endtask

    task automatic test_overflow();
        logic [BS-1:0] ent [7];
        logic [WS-1:0] seen [$];
        logic [WS-1:0] exp_w;
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            ent[e-1] = BS'($urandom);
            tick(ent[e-1], 4'b1111, 1'b0);
            if (e >= 2) seen.push_back(valid_out ? word_out : 4'hx);
            if (e == 5 || e == 6) begin
                checks++;
                if (fifo_count !== 3'd4 || overflow !== 1'b0)
                    begin errors++; $display("FAIL ovf_count_e%0d count=%0d ovf=%b exp 4/0", e, fifo_count, overflow); end
            end
        end
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4)
            begin errors++; $display("FAIL ovf_set ovf=%b count=%0d exp 1/4", overflow, fifo_count); end
        for (int i = 0; i < 18; i++) begin
            tick('0, '0, 1'b0);
            seen.push_back(valid_out ? word_out : 4'hx);
        end
        for (int k = 0; k < 24; k++) begin
            exp_w = WS'(ent[k/4] >> ((3 - k % 4) * WS));
            checks++;
            if (seen[k] !== exp_w)
                begin errors++; $display("FAIL ovf_stream%0d word=%h exp=%h", k, seen[k], exp_w); end
        end
        tick('0, '0, 1'b0);
        checks++;
        if (estado !== 2'b00 || overflow !== 1'b1 || valid_out !== 1'b0)
            begin errors++; $display("FAIL ovf_hold st=%0d ovf=%b v=%b exp 0/1/0", estado, overflow, valid_out); end
    endtask

    task automatic test_error();
        do_reset();
        for (int e = 1; e <= 7; e++) tick(BS'($urandom), 4'b1111, 1'b0);
        for (int e = 8; e <= 10; e++) tick('0, '0, 1'b0);
        checks++;
        if (fifo_count !== 3'd3 || overflow !== 1'b1)
            begin errors++; $display("FAIL err_pre count=%0d ovf=%b exp 3/1", fifo_count, overflow); end
        tick('0, '0, 1'b0);
        tick(16'hBEEF, 4'b1111, 1'b1);
        checks++;
        if (outs !== {4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 2'b10})
            begin errors++; $display("FAIL err_flush outs=%h exp=%h", outs, {4'h0, 3'b000, 3'd0, 1'b1, 1'b1, 2'b10}); end
        tick('0, '0, 1'b0);
        checks++;
        if (outs !== {4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2'b00})
            begin errors++; $display("FAIL err_exit outs=%h exp=%h", outs, {4'h0, 3'b000, 3'd0, 1'b1, 1'b0, 2'b00}); end
        tick(16'hABCD, 4'b1111, 1'b0);
        tick('0, '0, 1'b0);
        checks++;
        if (word_out !== 4'hA || sop_out !== 1'b1 || estado !== 2'b01)
            begin errors++; $display("FAIL err_resume word=%h sop=%b st=%0d exp A/1/1", word_out, sop_out, estado); end
    endtask

    task automatic test_async_reset();
        logic [WS-1:0] w [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
        do_reset();
        tick(16'h1234, 4'b1111, 1'b0);
        tick(16'h5678, 4'b1111, 1'b0);
        tick(16'h9ABC, 4'b1111, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (outs !== 14'h0) begin errors++; $display("FAIL areset_mid outs=%h exp=%h", outs, 14'h0); end
        #1 reset = 1'b1;
        tick(16'hF0F0, 4'b1111, 1'b0);
        checks++;
        if (valid_out !== 1'b0 || fifo_count !== 3'd1)
            begin errors++; $display("FAIL areset_latency v=%b count=%0d exp 0/1", valid_out, fifo_count); end
        for (int i = 0; i < 4; i++) begin
            tick('0, '0, 1'b0);
            checks++;
            if (word_out !== w[i] || valid_out !== 1'b1)
                begin errors++; $display("FAIL areset_word%0d word=%h v=%b exp %h/1", i, word_out, valid_out, w[i]); end
        end
        tick('0, '0, 1'b0);
        checks++;
        if (estado !== 2'b00 || valid_out !== 1'b0)
            begin errors++; $display("FAIL areset_end st=%0d v=%b exp 0/0", estado, valid_out); end
    endtask

    task automatic test_random();
        logic [13:0]   exp;
        logic [WS-1:0] ew;
        logic [WN-1:0] c;
        int            density;
        for (int b = 0; b < 8; b++) begin
            do_reset();
            density = $urandom_range(2, 14);
            for (int i = 0; i < 120; i++) begin
                c = ($urandom_range(0, 31) < density) ? WN'($urandom_range(1, 15)) : '0;
                tick(BS'($urandom), c, $urandom_range(0, 49) == 0);
                ew = m_left > 0 ? WS'(m_data >> ((m_left - 1) * WS)) : '0;
                exp = {ew, 1'(m_left > 0 && m_mask[m_left-1]), 1'(m_left == WN), 1'(m_left == 1),
                       3'(mq_data.size()), 1'(m_ovf), 1'(m_err),
                       m_in_err ? 2'b10 : (m_left > 0 ? 2'b01 : 2'b00)};
                checks++;
                if (outs !== exp)
                    begin errors++; $display("FAIL random_b%0d_c%0d outs=%h exp=%h", b, i, outs, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask();
        test_overflow();
        test_error();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
